// File: rtl/rns_compare_seq.sv
// Sequential RNS magnitude comparator: mixed-radix conversion of two three-residue
// operands over two cycles, then a lexicographic digit compare with optional signed view.
module rns_compare_seq #(
  parameter int M1 = 9,
  parameter int M2 = 8,
  parameter int M3 = 7,
  localparam int W1 = $clog2(M1),
  localparam int W2 = $clog2(M2),
  localparam int W3 = $clog2(M3)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W1-1:0] i_x1,
  input  logic [W2-1:0] i_x2,
  input  logic [W3-1:0] i_x3,
  input  logic [W1-1:0] i_y1,
  input  logic [W2-1:0] i_y2,
  input  logic [W3-1:0] i_y3,
  input  logic          i_mode,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  output logic          o_le,
  output logic          o_eq,
  output logic          o_gr,
  output logic          o_out_valid,
  input  logic          i_out_ready
);

  localparam int WD = W1 + W2 + W3;

  function automatic int f_inv(input int a, input int m);
    int r;
    r = 0;
    for (int k = 1; k < m; k++) begin
      if ((((a % m) * k) % m == 1) && (r == 0)) begin
        r = k;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // One MRC step: ((x - a) * inv) mod m, kept non-negative by adding m first.
  function automatic int f_mrc(input int x, input int a, input int inv, input int m);
    return ((x + m - (a % m)) * inv) % m;
  endfunction

  localparam int INV12 = f_inv(M1, M2);
  localparam int INV13 = f_inv(M1, M3);
  localparam int INV23 = f_inv(M2, M3);
  localparam int MR    = M1 * M2 * M3;
  localparam int HV    = (MR + 1) / 2;
  localparam int H1    = HV % M1;
  localparam int H2    = (HV / M1) % M2;
  localparam int H3    = HV / (M1 * M2);
  localparam logic [WD-1:0] HCAT = {W3'(H3), W2'(H2), W1'(H1)};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MRC1 = 3'd1,
    S_MRC2 = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W1-1:0] r_x1, r_y1;
  logic [W2-1:0] r_x2, r_y2, r_a2, r_b2;
  logic [W3-1:0] r_x3, r_y3, r_a3, r_b3;
  logic          r_mode;
  logic          r_in_ready;
  logic          r_le, r_eq, r_gr, r_out_valid;

  logic w_capture, w_do_mrc1, w_do_mrc2, w_do_cmp, w_release;
  logic [WD-1:0] w_da, w_db;
  logic w_sa, w_sb, w_lt, w_gt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = (i_in_valid && r_in_ready) ? S_MRC1 : S_IDLE;
      S_MRC1:  w_state_nxt = S_MRC2;
      S_MRC2:  w_state_nxt = S_CMP;
      S_CMP:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = i_out_ready ? S_IDLE : S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    w_do_mrc1 = 1'b0;
    w_do_mrc2 = 1'b0;
    w_do_cmp  = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE:  w_capture = i_in_valid && r_in_ready;
      S_MRC1:  w_do_mrc1 = 1'b1;
      S_MRC2:  w_do_mrc2 = 1'b1;
      S_CMP:   w_do_cmp  = 1'b1;
      S_DONE:  w_release = i_out_ready;
      default: w_release = 1'b0;
    endcase
  end

  // Mixed-radix digits are (a3, a2, a1) with a1 = x1, so concatenation compares lexicographically.
  assign w_da = {r_a3, r_a2, r_x1};
  assign w_db = {r_b3, r_b2, r_y1};
  assign w_sa = (w_da >= HCAT);
  assign w_sb = (w_db >= HCAT);

  always_comb begin
    w_lt = (w_da < w_db);
    w_gt = (w_da > w_db);
    if (r_mode && (w_sa != w_sb)) begin
      w_lt = w_sa;
      w_gt = w_sb;
    end else begin
      w_lt = w_lt;
      w_gt = w_gt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x1 <= '0; r_x2 <= '0; r_x3 <= '0;
      r_y1 <= '0; r_y2 <= '0; r_y3 <= '0;
      r_a2 <= '0; r_b2 <= '0; r_a3 <= '0; r_b3 <= '0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_le        <= 1'b0;
      r_eq        <= 1'b0;
      r_gr        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == S_IDLE);
      if (w_capture) begin
        r_x1   <= W1'(int'(i_x1) % M1);
        r_x2   <= W2'(int'(i_x2) % M2);
        r_x3   <= W3'(int'(i_x3) % M3);
        r_y1   <= W1'(int'(i_y1) % M1);
        r_y2   <= W2'(int'(i_y2) % M2);
        r_y3   <= W3'(int'(i_y3) % M3);
        r_mode <= i_mode;
      end else begin
        r_mode <= r_mode;
      end
      if (w_do_mrc1) begin
        r_a2 <= W2'(f_mrc(int'(r_x2), int'(r_x1), INV12, M2));
        r_b2 <= W2'(f_mrc(int'(r_y2), int'(r_y1), INV12, M2));
      end else begin
        r_a2 <= r_a2;
        r_b2 <= r_b2;
      end
      if (w_do_mrc2) begin
        r_a3 <= W3'(f_mrc(f_mrc(int'(r_x3), int'(r_x1), INV13, M3), int'(r_a2), INV23, M3));
        r_b3 <= W3'(f_mrc(f_mrc(int'(r_y3), int'(r_y1), INV13, M3), int'(r_b2), INV23, M3));
      end else begin
        r_a3 <= r_a3;
        r_b3 <= r_b3;
      end
      if (w_do_cmp) begin
        r_le        <= w_lt;
        r_gr        <= w_gt;
        r_eq        <= ~w_lt & ~w_gt;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_le        = r_le;
  assign o_eq        = r_eq;
  assign o_gr        = r_gr;
  assign o_out_valid = r_out_valid;

endmodule

// File: doc/rns_compare_seq.md
# rns_compare_seq

Sequential magnitude comparator for two operands in a three-moduli residue number system (RNS), with valid/ready handshakes on input and output. It is the parametrised successor of the combinational compare-against-constant blocks. Both operands are variable, the moduli are parameters, and a signed or unsigned interpretation is selected per transaction. Internally it performs a multi-cycle mixed-radix conversion (MRC) of both operands, then a lexicographic digit compare. It sits between RNS arithmetic units and control logic that needs ordering decisions.

## Interface
- M1, 9: first modulus. M1, M2, M3 must be pairwise coprime and ≥2; this is not checked in hardware.
- M2, 8: second modulus.
- M3, 7: third modulus. Dynamic range M = M1·M2·M3 (504 at defaults).
- Derived localparams:
  - Wi = clog2(Mi).
  - Modular inverses inv(M1) mod M2, inv(M1) mod M3, inv(M2) mod M3, computed at elaboration by constant function.
  - H = ceil(M/2) (252 at defaults) and its mixed-radix digits.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x1 / x2 / x3  in  W1 / W2 / W3  residues of operand A mod M1 / M2 / M3.
- y1 / y2 / y3  in  W1 / W2 / W3  residues of operand B mod M1 / M2 / M3.
- mode  in  1  0 = unsigned [0, M-1]; 1 = signed, where A ≥ H represents A−M.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands.
- le  out  1  A < B.
- eq  out  1  A == B.
- gr  out  1  A > B.
- out_valid  out  1  le/eq/gr hold a result.
- out_ready  in  1  consumer accepts result.

## Operation
- States: IDLE → MRC1 → MRC2 → CMP → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - When in_valid && in_ready at an edge, register all six residues and mode, then go to MRC1.
  - Each residue is reduced mod Mi at capture, so out-of-range input is legal (e.g. x1 = 12 is treated as 3).
- MRC1: a1 = x1; a2 = ((x2 − a1) · inv(M1)) mod M2. The same is computed for b1, b2 from B. Go to MRC2.
- MRC2: a3 = ((((x3 − a1) · inv(M1)) mod M3 − a2) · inv(M2)) mod M3. Same for b3. Go to CMP.
  - All modular subtractions are done non-negatively: add Mi before reducing.
- CMP:
  - Unsigned result is a lexicographic compare of (a3, a2, a1) against (b3, b2, b1).
  - If mode = 1: sA = (a3, a2, a1) ≥ digits(H), and likewise sB for B.
    - If sA ≠ sB, the operand with sign 1 is the smaller.
    - Otherwise use the unsigned result.
  - Register le/eq/gr, set out_valid = 1, go to DONE.
- DONE:
  - le/eq/gr and out_valid are held stable while out_ready = 0.
  - On out_valid && out_ready at an edge: clear out_valid, go to IDLE.
- Whenever out_valid = 1, exactly one of le/eq/gr is 1.
- in_ready = 1 only in IDLE with rst_n high. in_valid is ignored in every other state.
- Reset (any state, including mid-conversion): immediately return to IDLE and discard the transaction. Reset values:
  - out_valid = 0, le = eq = gr = 0.
  - All operand and digit registers = 0.
  - in_ready = 0 while rst_n is low.
- No partial result is ever exposed after reset.

## Timing
- The accept edge is E0. Digits a2/b2 are registered at E1, a3/b3 at E2, and results with out_valid at E3.
  - out_valid is visible in the cycle after E3: latency 3 clocks from accept.
- If out_ready = 1 when out_valid rises, the result is consumed at E4 and in_ready rises after E4. The next accept is at E5 at the earliest.
  - Peak throughput is 1 compare per 5 clocks.
- out_ready is sampled only in DONE. Asserting it earlier has no effect.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst_n low during MRC2 → out_valid = 0 and le/eq/gr = 0 immediately. After release, in_ready = 1, and a new compare of A=3 vs B=5 yields le = 1 at E3.
- Equality: A = 10 (1, 2, 3) vs B = 10 (1, 2, 3), mode 0 → eq = 1, le = gr = 0, out_valid exactly 3 clocks after accept.
- Sign mode: A = 503 (8, 7, 6) vs B = 0 (0, 0, 0) → gr = 1 with mode 0, le = 1 with mode 1. A = 251 (8, 3, 6) vs B = 252 (0, 4, 0) → le with mode 0, gr with mode 1.
- Backpressure: hold out_ready = 0 for 10 clocks with in_valid = 1 and changing x/y → results and out_valid are stable, in_ready = 0, and no new capture occurs. The released result matches the first operands.
- Out-of-range residues: x = (12, 2, 3) vs y = (3, 2, 3) → eq = 1.
- Exhaustive sweep: all 504 A against B ∈ {0, 10, 251, 252, 503}, both modes, with random out_ready stalls → every result matches an integer reference model.
